// File: rtl/fetch_pc_unit.sv
// IF-stage PC sequencer and IF/ID register, with mispredict detection against EX resolution.
// Latency: fetch PC -> IF/ID 1 cycle; mispredict in cycle N -> corrected current_pc in N+1.
// Backpressure: stall holds PC and IF/ID; a mispredict redirects and bubbles even under stall.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      predicted_pc,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_pred_pc,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      current_pc,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      if_id_inst,
    output logic [31:0]      if_id_pred_pc,
    output logic             if_id_valid,
    output logic             flush,
    output logic             bp_update,
    output logic [31:0]      bp_prev_pc,
    output logic             bp_taken,
    output logic [31:0]      bp_target,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] correct_next;
    logic        mispredict;

    // Fall-through address wraps modulo 2^32, so a branch at 0xFFFF_FFFC falls through to 0.
    always_comb begin
        correct_next = 32'd0;
        if (ex_taken) begin
            correct_next = {ex_target[31:2], 2'b00};
        end else begin
            correct_next = ex_pc + 32'd4;
        end
    end

    assign mispredict = ex_valid & ~reset & (ex_pred_pc != correct_next);
    assign flush      = mispredict;

    assign bp_update  = ex_valid & ~reset;
    assign bp_prev_pc = ex_pc;
    assign bp_taken   = ex_taken;
    assign bp_target  = ex_target & ~32'h3;

    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc <= RESET_PC;
        end else if (mispredict) begin
            current_pc <= correct_next;
        end else if (!stall) begin
            current_pc <= predicted_pc;
        end
    end

    // A killed entry carries no meaningful pc/pred_pc, so zero them rather than hold stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_pc      <= 32'd0;
            if_id_inst    <= NOP_INST;
            if_id_pred_pc <= 32'd0;
            if_id_valid   <= 1'b0;
        end else if (mispredict) begin
            if_id_pc      <= 32'd0;
            if_id_inst    <= NOP_INST;
            if_id_pred_pc <= 32'd0;
            if_id_valid   <= 1'b0;
        end else if (!stall) begin
            if_id_pc      <= current_pc;
            if_id_inst    <= imem_rdata;
            if_id_pred_pc <= predicted_pc;
            if_id_valid   <= 1'b1;
        end
    end

    // Statistics keep counting through stalls and stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            if (ex_valid && (branch_cnt != CNT_MAX)) begin
                branch_cnt <= branch_cnt + CNT_ONE;
            end
            if (mispredict && (mispredict_cnt != CNT_MAX)) begin
                mispredict_cnt <= mispredict_cnt + CNT_ONE;
            end
        end
    end

endmodule
